// File: rtl/jtframe_cen_rst_seq.sv
// Fractional N/M clock-enable generator with a lock-aware, staggered per-channel reset sequencer.
// Optional feature macro JTFRAME_CEN_HALF_EN adds cen_h, a half-rate enable on every second cen pulse.
module jtframe_cen_rst_seq #(
  parameter int CH         = 4,
  parameter int W          = 16,
  parameter int RST_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pll_locked,
  input  logic            game_rst,
  input  logic [CH*W-1:0] num,
  input  logic [CH*W-1:0] den,
  output logic [CH-1:0]   cen,
`ifdef JTFRAME_CEN_HALF_EN
  output logic [CH-1:0]   cen_h,
`endif
  output logic [CH-1:0]   rst_ch,
  output logic            ready
);

  localparam int            CW       = $clog2(RST_CYCLES);
  localparam int            IW       = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(RST_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(CH - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK,
    STRETCH,
    RELEASE,
    RUN
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CH-1:0] rst_ch_q, rst_ch_d;
  logic          lk_meta_q, lk_q;
  logic [CH-1:0] chan_clr;

  // pll_locked comes from another clock domain; two flops before anything looks at it.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      lk_meta_q <= 1'b0;
      lk_q      <= 1'b0;
    end else begin
      lk_meta_q <= pll_locked;
      lk_q      <= lk_meta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= WAIT_LOCK;
      cnt_q    <= '0;
      idx_q    <= '0;
      rst_ch_q <= '1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      rst_ch_q <= rst_ch_d;
    end
  end

  // NOTE: every variable gets a default first, so no path can leave a latch behind.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    rst_ch_d = rst_ch_q;
    if (!lk_q) begin
      // Losing lock overrides a simultaneous game_rst.
      state_d  = WAIT_LOCK;
      cnt_d    = '0;
      idx_d    = '0;
      rst_ch_d = '1;
    end else begin
      unique case (state_q)
        WAIT_LOCK: begin
          state_d  = STRETCH;
          cnt_d    = '0;
          rst_ch_d = '1;
        end
        STRETCH: begin
          rst_ch_d = '1;
          if (game_rst) begin
            cnt_d = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = RELEASE;
            idx_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        RELEASE: begin
          if (game_rst) begin
            state_d  = STRETCH;
            cnt_d    = '0;
            rst_ch_d = '1;
          end else begin
            rst_ch_d[idx_q] = 1'b0;
            idx_d           = idx_q + IW'(1);
            if (idx_q == IDX_LAST) state_d = RUN;
          end
        end
        RUN: begin
          if (game_rst) begin
            state_d  = STRETCH;
            cnt_d    = '0;
            rst_ch_d = '1;
          end
        end
      endcase
    end
  end

  always_comb begin
    ready  = (state_q == RUN);
    rst_ch = rst_ch_q;
  end

  // A channel is held clear both while in reset and on the edge its reset asserts,
  // so cen drops together with rst_ch and counting begins the edge after release.
  assign chan_clr = rst_ch_q | rst_ch_d;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [W-1:0] nv, mv;
    logic [W:0]   acc_q, acc_d, sum;
    logic         cen_q, cen_d;

    assign nv  = num[i*W +: W];
    assign mv  = den[i*W +: W];
    // With acc < M and N < M the sum cannot overflow W+1 bits.
    assign sum = acc_q + {1'b0, nv};

    always_comb begin
      acc_d = '0;
      cen_d = 1'b0;
      if (chan_clr[i] || nv == '0 || mv == '0) begin
        acc_d = '0;
      end else if (nv >= mv) begin
        cen_d = 1'b1;
      end else if (acc_q >= {1'b0, mv}) begin
        // M lowered below the running phase: one catch-up pulse, then restart.
        cen_d = 1'b1;
      end else if (sum >= {1'b0, mv}) begin
        acc_d = sum - {1'b0, mv};
        cen_d = 1'b1;
      end else begin
        acc_d = sum;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        acc_q <= '0;
        cen_q <= 1'b0;
      end else begin
        acc_q <= acc_d;
        cen_q <= cen_d;
      end
    end

    assign cen[i] = cen_q;

`ifdef JTFRAME_CEN_HALF_EN
    logic tog_q, cen_h_q;

    always_ff @(posedge clk) begin
      if (rst || chan_clr[i]) begin
        tog_q   <= 1'b0;
        cen_h_q <= 1'b0;
      end else begin
        cen_h_q <= cen_d & tog_q;
        if (cen_d) tog_q <= ~tog_q;
      end
    end

    assign cen_h[i] = cen_h_q;
`endif
  end

endmodule

// File: tb/tb_jtframe_cen_rst_seq.sv
// Self-checking bench for jtframe_cen_rst_seq: scoreboard queues of expected reset/ready
// snapshots and per-edge enable patterns, drained by a negedge monitor.
module tb_jtframe_cen_rst_seq;
  localparam int CH         = 4;
  localparam int W          = 16;
  localparam int RST_CYCLES = 32;
  localparam int SEQ_LAT    = RST_CYCLES + 3;  // pll_locked first sampled -> rst_ch[0] low

  logic            clk = 1'b0;
  logic            rst, pll_locked, game_rst;
  logic [CH*W-1:0] num, den;
  logic [CH-1:0]   cen, rst_ch;
  logic            ready;
`ifdef JTFRAME_CEN_HALF_EN
  logic [CH-1:0]   cen_h;
`endif

  jtframe_cen_rst_seq #(.CH(CH), .W(W), .RST_CYCLES(RST_CYCLES)) dut (
    .clk       (clk),
    .rst       (rst),
    .pll_locked(pll_locked),
    .game_rst  (game_rst),
    .num       (num),
    .den       (den),
    .cen       (cen),
`ifdef JTFRAME_CEN_HALF_EN
    .cen_h     (cen_h),
`endif
    .rst_ch    (rst_ch),
    .ready     (ready)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at edge %0d", tag, got, exp, edge_cnt);
    end
  endtask

  typedef struct {
    int            at;
    logic [CH-1:0] rst_ch;
    logic          ready;
    logic          chk_cen;
  } snap_t;

  typedef struct {
    int            at;
    logic [CH-1:0] mask;
    logic [CH-1:0] cen;
    logic [CH-1:0] cen_h;
  } pulse_t;

  snap_t  snap_q[$];
  pulse_t pulse_q[$];

  int   n_arr[CH] = '{1, 3, 0, 5};
  int   m_arr[CH] = '{4, 8, 7, 5};
  int   cnt[CH];
  int   cnt0_100, consec1, rel0;
  logic prev1;

  task automatic apply_cfg();
    for (int i = 0; i < CH; i++) begin
      num[i*W +: W] = n_arr[i][W-1:0];
      den[i*W +: W] = m_arr[i][W-1:0];
    end
  endtask

  task automatic push_snap(input int at, input logic [CH-1:0] r, input logic rdy, input logic cc);
    snap_t s;
    s.at = at; s.rst_ch = r; s.ready = rdy; s.chk_cen = cc;
    snap_q.push_back(s);
  endtask

  // Still held one edge before r, then one channel per edge, ready with the last.
  task automatic push_release(input int r);
    logic [CH-1:0] v;
    push_snap(r - 1, '1, 1'b0, 1'b0);
    for (int k = 0; k < CH; k++) begin
      v = '1;
      v = v << (k + 1);
      push_snap(r + k, v, (k == CH - 1), 1'b0);
    end
  endtask

  // Ideal N/M enable: the k-th counted edge pulses when floor(k*N/M) steps.
  function automatic logic pulse_at(input int k, input int n, input int m);
    if (n == 0 || m == 0 || k < 1) return 1'b0;
    return ((k * n) / m) != (((k - 1) * n) / m);
  endfunction

  task automatic push_window(input int r, input int lo, input int hi);
    int     pc[CH];
    pulse_t p;
    for (int i = 0; i < CH; i++) pc[i] = 0;
    for (int e = lo; e <= hi; e++) begin
      p.at = e; p.mask = '1; p.cen = '0; p.cen_h = '0;
      for (int i = 0; i < CH; i++) begin
        if (pulse_at(e - (r + i), n_arr[i], m_arr[i])) begin
          pc[i]++;
          p.cen[i]   = 1'b1;
          p.cen_h[i] = (pc[i] % 2 == 0);
        end
      end
      pulse_q.push_back(p);
    end
  endtask

  task automatic wait_until(input int e);
    while (edge_cnt < e) @(negedge clk);
  endtask

  initial begin : monitor
    snap_t  s;
    pulse_t p;
    forever begin
      @(negedge clk);
      if (snap_q.size() > 0 && snap_q[0].at == edge_cnt) begin
        s = snap_q.pop_front();
        check("rst_ch", rst_ch, s.rst_ch);
        check("ready", ready, s.ready);
        if (s.chk_cen) check("cen_off", cen, 0);
      end
      if (pulse_q.size() > 0 && pulse_q[0].at == edge_cnt) begin
        p = pulse_q.pop_front();
        check("cen", cen & p.mask, p.cen);
`ifdef JTFRAME_CEN_HALF_EN
        check("cen_h", cen_h & p.mask, p.cen_h);
`endif
        for (int i = 0; i < CH; i++) if (p.mask[i] && cen[i]) cnt[i]++;
        if (cen[0] && edge_cnt <= rel0 + 100) cnt0_100++;
        if (cen[1] && prev1) consec1++;
        prev1 = cen[1];
      end
    end
  end

  initial begin : stimulus
    int e, r;
    rst = 1'b1; pll_locked = 1'b0; game_rst = 1'b0;
    apply_cfg();
    for (int i = 0; i < CH; i++) cnt[i] = 0;
    cnt0_100 = 0; consec1 = 0; prev1 = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_cen", cen, 0);
    check("reset_rst_ch", rst_ch, 4'hF);
    check("reset_ready", ready, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("wait_lock_rst_ch", rst_ch, 4'hF);

    // Lock, stretch, staggered release, then long-run enable rates.
    pll_locked = 1'b1;
    rel0 = edge_cnt + 1 + SEQ_LAT;
    push_release(rel0);
    push_window(rel0, rel0 + 1, rel0 + 801);
    wait_until(rel0 + 802);
    check("ch0_pulses_100", cnt0_100, 25);
    check("ch0_pulses", cnt[0], 200);
    check("ch1_pulses_800", cnt[1], 300);
    check("ch1_consecutive", consec1, 0);
    check("ch2_pulses", cnt[2], 0);
    check("ch3_pulses", cnt[3], 798);

    // One-cycle lock drop in RUN.
    e = edge_cnt;
    pll_locked = 1'b0;
    push_snap(e + 2, '0, 1'b1, 1'b0);
    push_snap(e + 3, '1, 1'b0, 1'b1);
    push_release(e + 37);
    @(negedge clk);
    pll_locked = 1'b1;
    wait_until(e + 42);

    // One-cycle game_rst in RUN.
    e = edge_cnt;
    game_rst = 1'b1;
    push_snap(e + 1, '1, 1'b0, 1'b1);
    push_release(e + 34);
    @(negedge clk);
    game_rst = 1'b0;
    wait_until(e + 40);

    // game_rst held through STRETCH keeps the counter at zero.
    e = edge_cnt;
    game_rst = 1'b1;
    push_snap(e + 1, '1, 1'b0, 1'b0);
    push_snap(e + 34, '1, 1'b0, 1'b0);
    push_release(e + 43);
    repeat (10) @(negedge clk);
    game_rst = 1'b0;
    wait_until(e + 48);

    // Lock loss coinciding with game_rst: WAIT_LOCK wins, adding one edge to the release.
    e = edge_cnt;
    pll_locked = 1'b0;
    push_snap(e + 3, '1, 1'b0, 1'b1);
    push_release(e + 37);
    @(negedge clk);
    pll_locked = 1'b1;
    @(negedge clk);
    game_rst = 1'b1;
    @(negedge clk);
    game_rst = 1'b0;
    wait_until(e + 42);

    // Channel 0 at 1/8, then M lowered to 4 with acc=6: catch-up pulse, then every 4.
    m_arr[0] = 8;
    apply_cfg();
    e = edge_cnt;
    game_rst = 1'b1;
    r = e + 34;
    push_release(r);
    for (int t = r + 1; t <= r + 40; t++) begin
      pulse_t p;
      p.at = t; p.mask = 4'b0001; p.cen = '0; p.cen_h = '0;
      if (t >= r + 7 && (t - (r + 7)) % 4 == 0) begin
        p.cen[0]   = 1'b1;
        p.cen_h[0] = ((t - (r + 7)) / 4) % 2 == 1;
      end
      pulse_q.push_back(p);
    end
    @(negedge clk);
    game_rst = 1'b0;
    wait_until(r + 6);
    m_arr[0] = 4;
    apply_cfg();
    wait_until(r + 42);

    check("snap_queue_drained", snap_q.size(), 0);
    check("pulse_queue_drained", pulse_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, edge %0d", edge_cnt);
    $fatal(1);
  end

endmodule
